ecc_point_double_unit: RTL and testbench

//  Responder side of the point-doubling handshake (DQ_IN_VALID / DQ_OUT_VALID) driven by the

---
 rtl/ecc_point_double_unit_pkg.sv | 67 ++++++
 rtl/ecc_point_double_unit_mult.sv | 46 ++++
 rtl/ecc_point_double_unit.sv | 179 +++++++++++++++++
 tb/tb_ecc_point_double_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_point_double_unit_pkg.sv
// Shared GF(2^233) constants, FSM/step types and combinational field helpers
// for the Lopez-Dahab point-doubling unit.
package ecc_pkg;

    localparam int M = 233;
    // Low terms of the reduction trinomial x^233 + x^74 + 1.
    localparam logic [M-1:0] POLY = M'(1) | (M'(1) << 74);
    localparam logic [M-1:0] B_COEF_DEFAULT = M'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_SQ, OP_ADD, OP_MUL, OP_NOP} op_t;
    typedef enum logic [2:0] {S_X, S_Y, S_Z, S_T1, S_T2, S_X3, S_Z3, S_B} src_t;
    typedef enum logic [2:0] {D_T1, D_T2, D_X3, D_Y3, D_Z3} dest_t;

    typedef struct packed {
        op_t   op;
        src_t  a;
        src_t  b;
        dest_t d;
    } step_t;

    localparam logic [3:0] STEP_FIRST  = 4'd1;
    localparam logic [3:0] STEP_A_TERM = 4'd10;
    localparam logic [3:0] STEP_LAST   = 4'd13;

    function automatic step_t step_entry(input logic [3:0] ptr);
        case (ptr)
            4'd1:    return '{OP_SQ,  S_X,  S_X,  D_T1};
            4'd2:    return '{OP_SQ,  S_Z,  S_Z,  D_T2};
            4'd3:    return '{OP_MUL, S_T1, S_T2, D_Z3};
            4'd4:    return '{OP_SQ,  S_T1, S_T1, D_T1};
            4'd5:    return '{OP_SQ,  S_T2, S_T2, D_T2};
            4'd6:    return '{OP_MUL, S_B,  S_T2, D_T2};
            4'd7:    return '{OP_ADD, S_T1, S_T2, D_X3};
            4'd8:    return '{OP_SQ,  S_Y,  S_Y,  D_T1};
            4'd9:    return '{OP_ADD, S_T1, S_T2, D_T1};
            4'd10:   return '{OP_ADD, S_T1, S_Z3, D_T1};
            4'd11:   return '{OP_MUL, S_T1, S_X3, D_T1};
            4'd12:   return '{OP_MUL, S_T2, S_Z3, D_T2};
            4'd13:   return '{OP_ADD, S_T1, S_T2, D_Y3};
            default: return '{OP_NOP, S_T1, S_T1, D_T1};
        endcase
    endfunction

    function automatic logic [M-1:0] gf_add(input logic [M-1:0] a, input logic [M-1:0] b);
        return a ^ b;
    endfunction

    // Multiply by x: shift left and fold the overflow bit back through POLY.
    function automatic logic [M-1:0] gf_mulx(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (POLY & {M{a[M-1]}});
    endfunction

    function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] a);
        logic [2*M-1:0] t;
        t = '0;
        for (int i = 0; i < M; i++) t[2*i] = a[i];
        for (int i = 2*M-2; i >= M; i--) begin
            if (t[i]) begin
                t[i] = 1'b0;
                t[i-M +: M] = t[i-M +: M] ^ POLY;
            end
        end
        return t[M-1:0];
    endfunction

endpackage

// File: rtl/ecc_point_double_unit_mult.sv
// Bit-serial MSB-first GF(2^M) multiplier. Hold start high for M cycles; done and
// the final product p are valid combinationally during the last of them.
module gf2m_serial_mult
    import ecc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         done,
    output logic [M-1:0] p
);

    localparam int IW = $clog2(M);

    logic          busy;
    logic [M-1:0]  acc;
    logic [IW-1:0] idx_r;
    logic [M-1:0]  acc_cur;
    logic [IW-1:0] idx_cur;

    // The first cycle of a request works from a zero accumulator and bit M-1,
    // so the product is ready on the M-th edge rather than the (M+1)-th.
    always_comb begin
        acc_cur = busy ? acc : '0;
        idx_cur = busy ? idx_r : IW'(M-1);
        p       = gf_mulx(acc_cur) ^ (a & {M{b[idx_cur]}});
        done    = start && (idx_cur == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            acc   <= '0;
            idx_r <= '0;
        end else if (!start || idx_cur == '0) begin
            busy <= 1'b0;
        end else begin
            busy  <= 1'b1;
            acc   <= p;
            idx_r <= idx_cur - IW'(1);
        end
    end

endmodule

// File: rtl/ecc_point_double_unit.sv
// Lopez-Dahab point doubling over GF(2^233) using a fixed 13-step micro-op schedule.
// Optional DQ_INF_BYPASS_EN: Z_IN==0 returns (1,0,0) one edge after accept.
module ecc_point_double_unit
    import ecc_pkg::*;
#(
    parameter logic [M-1:0] B_COEF   = B_COEF_DEFAULT,
    parameter bit           A_IS_ONE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         dq_in_valid,
    input  logic [M-1:0] x_in,
    input  logic [M-1:0] y_in,
    input  logic [M-1:0] z_in,
    output logic         dq_out_valid,
    output logic [M-1:0] x_out,
    output logic [M-1:0] y_out,
    output logic [M-1:0] z_out,
    output logic         dq_busy
);

    // Handshake: dq_in_valid is sampled only in IDLE or DONE; the sampling edge
    // captures the point, enters RUN and drops dq_out_valid. dq_out_valid is a
    // level that stays high in DONE until the next accepted request.
    state_t       state, state_next;
    logic [3:0]   ptr;
    logic         bypass_r;
    logic         accept, fire, finish;
    step_t        step;
    logic [M-1:0] x_r, y_r, z_r, t1, t2, x3, z3;
    logic [M-1:0] opnd_a, opnd_b, res;
    logic         mul_start, mul_done;
    logic [M-1:0] mul_p;

    always_comb begin
        step = step_entry(ptr);
        if (ptr == STEP_A_TERM && !A_IS_ONE) step.op = OP_NOP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fire       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (dq_in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (bypass_r) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else if (step.op != OP_MUL || mul_done) begin
                    fire = 1'b1;
                    if (ptr == STEP_LAST) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dq_out_valid = (state == DONE);
    assign dq_busy      = (state == RUN);
    assign mul_start    = (state == RUN) && !bypass_r && (step.op == OP_MUL);

    always_comb begin
        opnd_a = '0;
        unique case (step.a)
            S_X:     opnd_a = x_r;
            S_Y:     opnd_a = y_r;
            S_Z:     opnd_a = z_r;
            S_T1:    opnd_a = t1;
            S_T2:    opnd_a = t2;
            S_X3:    opnd_a = x3;
            S_Z3:    opnd_a = z3;
            S_B:     opnd_a = B_COEF;
            default: opnd_a = '0;
        endcase
        opnd_b = '0;
        unique case (step.b)
            S_X:     opnd_b = x_r;
            S_Y:     opnd_b = y_r;
            S_Z:     opnd_b = z_r;
            S_T1:    opnd_b = t1;
            S_T2:    opnd_b = t2;
            S_X3:    opnd_b = x3;
            S_Z3:    opnd_b = z3;
            S_B:     opnd_b = B_COEF;
            default: opnd_b = '0;
        endcase
    end

    always_comb begin
        res = opnd_a;
        unique case (step.op)
            OP_SQ:  res = gf_sqr(opnd_a);
            OP_ADD: res = gf_add(opnd_a, opnd_b);
            OP_MUL: res = mul_p;
            OP_NOP: res = opnd_a;
        endcase
    end

    gf2m_serial_mult u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (opnd_a),
        .b     (opnd_b),
        .done  (mul_done),
        .p     (mul_p)
    );

`ifdef DQ_INF_BYPASS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      bypass_r <= 1'b0;
        else if (accept) bypass_r <= (z_in == '0);
    end
`else
    assign bypass_r = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            x_r   <= '0;
            y_r   <= '0;
            z_r   <= '0;
            t1    <= '0;
            t2    <= '0;
            x3    <= '0;
            z3    <= '0;
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
        end else begin
            if (accept) begin
                x_r <= x_in;
                y_r <= y_in;
                z_r <= z_in;
                ptr <= STEP_FIRST;
            end else if (fire) begin
                if (step.op != OP_NOP) begin
                    unique case (step.d)
                        D_T1:    t1 <= res;
                        D_T2:    t2 <= res;
                        D_X3:    x3 <= res;
                        D_Z3:    z3 <= res;
                        default: ;
                    endcase
                end
                ptr <= (ptr == STEP_LAST) ? 4'd0 : ptr + 4'd1;
            end
            // Y3 is produced by the last step itself and goes straight to y_out.
            if (finish) begin
                if (bypass_r) begin
                    x_out <= M'(1);
                    y_out <= '0;
                    z_out <= '0;
                end else begin
                    x_out <= x3;
                    y_out <= res;
                    z_out <= z3;
                end
            end
        end
    end

endmodule

// File: tb/tb_ecc_point_double_unit.sv
// Self-checking bench for ecc_point_double_unit (default parameters: b=1, a=1).
// Expected points come from the Lopez-Dahab doubling formulas over GF(2^233).
module tb_ecc_point_double_unit;

    localparam int W        = 233;
    localparam int LAT      = 4*W + 9;
    localparam int MAX_WAIT = 2000;
    localparam logic [W-1:0] B_REF = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         dq_in_valid = 1'b0;
    logic [W-1:0] x_in = '0, y_in = '0, z_in = '0;
    logic         dq_out_valid, dq_busy;
    logic [W-1:0] x_out, y_out, z_out;

    int tests_run = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_q[$];

    ecc_point_double_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dq_in_valid  (dq_in_valid),
        .x_in         (x_in),
        .y_in         (y_in),
        .z_in         (z_in),
        .dq_out_valid (dq_out_valid),
        .x_out        (x_out),
        .y_out        (y_out),
        .z_out        (z_out),
        .dq_busy      (dq_busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod, aw;
        prod = '0;
        aw   = {{W{1'b0}}, a};
        for (int i = 0; i < W; i++) if (b[i]) prod = prod ^ (aw << i);
        for (int i = 2*W-2; i >= W; i--) begin
            if (prod[i]) begin
                prod[i]        = 1'b0;
                prod[i-W]      = ~prod[i-W];
                prod[i-W+74]   = ~prod[i-W+74];
            end
        end
        return prod[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_sqr(input logic [W-1:0] a);
        return ref_mul(a, a);
    endfunction

    // 2P in LD coordinates with a=1: Z3=X^2 Z^2, X3=X^4+bZ^4,
    // Y3=(Y^2 + aZ3 + bZ^4) X3 + bZ^4 Z3.
    task automatic ref_push(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        logic [W-1:0] bz4, rz, rx, ry;
        bz4 = ref_mul(B_REF, ref_sqr(ref_sqr(z)));
        rz  = ref_mul(ref_sqr(x), ref_sqr(z));
        rx  = ref_sqr(ref_sqr(x)) ^ bz4;
        ry  = ref_mul(ref_sqr(y) ^ rz ^ bz4, rx) ^ ref_mul(bz4, rz);
        exp_q.push_back(rx);
        exp_q.push_back(ry);
        exp_q.push_back(rz);
    endtask

    function automatic logic [W-1:0] rand_fe();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r[W-1:0];
    endfunction

    // ---------------- driver ----------------
    task automatic do_request(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                              input int pulse_a, input int pulse_b, input bit hold,
                              output int lat, output bit valid_acc, output bit busy_acc);
        @(negedge clk);
        x_in = x; y_in = y; z_in = z;
        dq_in_valid = 1'b1;
        @(posedge clk);
        #1;
        valid_acc = dq_out_valid;
        busy_acc  = dq_busy;
        lat = 0;
        while (lat < MAX_WAIT) begin
            @(negedge clk);
            dq_in_valid = hold || (lat + 1 == pulse_a) || (lat + 1 == pulse_b);
            x_in = rand_fe(); y_in = rand_fe(); z_in = rand_fe();
            @(posedge clk);
            lat++;
            #1;
            if (dq_out_valid) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (dq_out_valid !== 1'b0 || dq_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got valid=%b busy=%b expected 0 0", dq_out_valid, dq_busy);
        end
        tests_run++;
        if (x_out !== '0 || y_out !== '0 || z_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got x=%h y=%h z=%h expected zeros", x_out, y_out, z_out);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (dq_out_valid !== 1'b0 || dq_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_request: got valid=%b busy=%b expected 0 0", dq_out_valid, dq_busy);
        end
    endtask

    task automatic check_point(input string name, input int lat, input int exp_lat,
                               input logic [W-1:0] ex, input logic [W-1:0] ey, input logic [W-1:0] ez);
        tests_run++;
        if (lat !== exp_lat) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        tests_run++;
        if (x_out !== ex || y_out !== ey || z_out !== ez) begin
            tests_failed++;
            $display("FAIL %s_result: got (%h,%h,%h) expected (%h,%h,%h)", name, x_out, y_out, z_out, ex, ey, ez);
        end
    endtask

    task automatic test_known_points();
        int lat; bit va, ba;
        do_request(1, 0, 1, 0, 0, 1'b0, lat, va, ba);
        tests_run++;
        if (va !== 1'b0 || ba !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept_flags: got valid=%b busy=%b expected 0 1", va, ba);
        end
        check_point("p1", lat, LAT, 0, 1, 1);
        do_request(0, 1, 1, 0, 0, 1'b0, lat, va, ba);
        check_point("order2", lat, LAT, 1, 0, 0);
    endtask

    task automatic test_ignore_in_run();
        int lat; bit va, ba;
        do_request(1, 0, 1, 10, 500, 1'b0, lat, va, ba);
        check_point("ignore", lat, LAT, 0, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (dq_out_valid !== 1'b1 || dq_busy !== 1'b0 || y_out !== 1) begin
            tests_failed++;
            $display("FAIL done_hold: got valid=%b busy=%b y=%h expected 1 0 1", dq_out_valid, dq_busy, y_out);
        end
    endtask

    task automatic test_async_reset();
        int lat; bit va, ba;
        logic [W-1:0] x, y, z, ex, ey, ez;
        @(negedge clk);
        x_in = rand_fe(); y_in = rand_fe(); z_in = rand_fe();
        dq_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk) dq_in_valid = 1'b0;
        repeat (299) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (dq_out_valid !== 1'b0 || dq_busy !== 1'b0 || x_out !== '0 || y_out !== '0 || z_out !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got valid=%b busy=%b y=%h z=%h expected all 0", dq_out_valid, dq_busy, y_out, z_out);
        end
        @(negedge clk) rst_n = 1'b1;
        x = rand_fe(); y = rand_fe(); z = rand_fe();
        ref_push(x, y, z);
        do_request(x, y, z, 0, 0, 1'b0, lat, va, ba);
        ex = exp_q.pop_front(); ey = exp_q.pop_front(); ez = exp_q.pop_front();
        check_point("after_reset", lat, LAT, ex, ey, ez);
    endtask

    task automatic test_random();
        int lat; bit va, ba;
        logic [W-1:0] x, y, z, ex, ey, ez;
        for (int n = 0; n < 3; n++) begin
            x = rand_fe(); y = rand_fe(); z = rand_fe();
            if (n == 0) z = 2;
            ref_push(x, y, z);
            do_request(x, y, z, 0, 0, 1'b0, lat, va, ba);
            ex = exp_q.pop_front(); ey = exp_q.pop_front(); ez = exp_q.pop_front();
            check_point("random", lat, LAT, ex, ey, ez);
        end
    endtask

    task automatic test_infinity();
        int lat; bit va, ba;
        logic [W-1:0] y, ex, ey, ez;
        y = rand_fe();
`ifdef DQ_INF_BYPASS_EN
        do_request(5, y, 0, 0, 0, 1'b0, lat, va, ba);
        check_point("inf_bypass", lat, 1, 1, 0, 0);
`else
        ref_push(5, y, 0);
        do_request(5, y, 0, 0, 0, 1'b0, lat, va, ba);
        ex = exp_q.pop_front(); ey = exp_q.pop_front(); ez = exp_q.pop_front();
        check_point("inf_full", lat, LAT, ex, ey, ez);
        tests_run++;
        if (z_out !== '0) begin
            tests_failed++;
            $display("FAIL inf_z_zero: got %h expected 0", z_out);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int lat; bit va, ba;
        logic [W-1:0] x, y, z, ex, ey, ez;
        for (int n = 0; n < 3; n++) begin
            x = rand_fe(); y = rand_fe(); z = rand_fe();
            ref_push(x, y, z);
            do_request(x, y, z, 0, 0, 1'b1, lat, va, ba);
            tests_run++;
            if (va !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_valid_drop: got %b expected 0", va);
            end
            ex = exp_q.pop_front(); ey = exp_q.pop_front(); ez = exp_q.pop_front();
            check_point("b2b", lat, LAT, ex, ey, ez);
            #3;
            tests_run++;
            if (dq_out_valid !== 1'b1 || x_out !== ex || y_out !== ey || z_out !== ez) begin
                tests_failed++;
                $display("FAIL b2b_stable: got valid=%b x=%h expected 1 %h", dq_out_valid, x_out, ex);
            end
        end
        @(negedge clk) dq_in_valid = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (dq_out_valid !== 1'b1 || dq_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_release: got valid=%b busy=%b expected 1 0", dq_out_valid, dq_busy);
        end
    endtask

    initial begin
        test_reset();
        test_known_points();
        test_ignore_in_run();
        test_async_reset();
        test_random();
        test_infinity();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
